// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ack channel between fetch control and IM.
// The master side drives the request and address; IM answers with ack.
interface fetch_ctrl_if #(
    parameter int PC_W = 16
);
    logic            req;
    logic [PC_W-1:0] addr;
    logic            ack;

    modport master (
        output req,
        output addr,
        input  ack
    );

    modport slave (
        input  req,
        input  addr,
        output ack
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: next-PC arbitration, IM handshake with timeout,
// and IF/ID + ID/EX flush generation.
module fetch_ctrl #(
    parameter int              PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [PC_W-1:0] TRAP_VEC    = 'h0100,
    parameter int              INSTR_BYTES = 4,
    parameter int              TIMEOUT     = 15
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [PC_W-1:0] pc_cur_i,
    input  logic            load_use_hazard_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            trap_req_i,
    fetch_ctrl_if.master    im,
    output logic [PC_W-1:0] pc_next_o,
    output logic            pc_hold_o,
    output logic            if_valid_o,
    output logic            if_id_flush_o,
    output logic            id_ex_flush_o,
    output logic            fetch_err_o,
    output logic [1:0]      state_dbg_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0]      TO_CNT = 4'(TIMEOUT);
    localparam logic [PC_W-1:0] INCR   = PC_W'(INSTR_BYTES);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] redir_q, redir_d;
    logic            first_q, first_d;
    logic            req;
    logic            flush;
    logic            tmo;

    assign im.req        = req;
    assign im.addr       = pc_cur_i;
    assign if_id_flush_o = flush;
    assign id_ex_flush_o = flush;
    assign state_dbg_o   = state_q;
    assign tmo           = (cnt_q == TO_CNT) && !im.ack;

    // State, wait counter, pending redirect target and first-cycle flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            redir_q <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            redir_q <= redir_d;
            first_q <= first_d;
        end
    end

    // Next-PC priority: trap > timeout > redirect > load-use > sequential.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        redir_d     = redir_q;
        first_d     = 1'b0;
        req         = 1'b0;
        flush       = 1'b0;
        pc_hold_o   = 1'b1;
        pc_next_o   = pc_cur_i;
        if_valid_o  = 1'b0;
        fetch_err_o = 1'b0;
        unique case (state_q)
            BOOT: begin
                pc_next_o = RESET_PC;
                pc_hold_o = !rst_ni;
                first_d   = 1'b1;
                state_d   = FETCH;
            end
            FETCH: begin
                req = !(tmo && !trap_req_i);
                if (trap_req_i) begin
                    pc_next_o = TRAP_VEC;
                    pc_hold_o = 1'b0;
                    flush     = 1'b1;
                    cnt_d     = '0;
                end else if (tmo) begin
                    fetch_err_o = 1'b1;
                    pc_next_o   = TRAP_VEC;
                    pc_hold_o   = 1'b0;
                    flush       = 1'b1;
                    cnt_d       = '0;
                end else if (branch_taken_i && (im.ack || first_q)) begin
                    pc_next_o = branch_target_i;
                    pc_hold_o = 1'b0;
                    flush     = 1'b1;
                    cnt_d     = '0;
                end else if (branch_taken_i) begin
                    redir_d = branch_target_i;
                    flush   = 1'b1;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else if (load_use_hazard_i) begin
                    cnt_d = im.ack ? '0 : cnt_q + 4'd1;
                end else if (im.ack) begin
                    if_valid_o = 1'b1;
                    pc_hold_o  = 1'b0;
                    pc_next_o  = pc_cur_i + INCR;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DRAIN: begin
                req = !(tmo && !trap_req_i);
                if (trap_req_i) begin
                    pc_next_o = TRAP_VEC;
                    pc_hold_o = 1'b0;
                    flush     = 1'b1;
                    cnt_d     = '0;
                    state_d   = FETCH;
                end else if (tmo) begin
                    fetch_err_o = 1'b1;
                    pc_next_o   = TRAP_VEC;
                    pc_hold_o   = 1'b0;
                    flush       = 1'b1;
                    cnt_d       = '0;
                    state_d     = FETCH;
                end else if (im.ack) begin
                    pc_next_o = branch_taken_i ? branch_target_i : redir_q;
                    flush     = branch_taken_i;
                    pc_hold_o = 1'b0;
                    cnt_d     = '0;
                    state_d   = FETCH;
                end else begin
                    if (branch_taken_i) begin
                        redir_d = branch_target_i;
                        flush   = 1'b1;
                    end
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register model and
// a queue of expected per-cycle outputs.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        haz = 1'b0;
    logic        br = 1'b0;
    logic [15:0] tgt = '0;
    logic        trap = 1'b0;
    logic [15:0] pc_q;
    logic [15:0] nxt;
    logic        hold, vld, fl_ifid, fl_idex, err;
    logic [1:0]  st;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic        req;
        logic [15:0] pc;
        logic        hold;
        logic [15:0] nxt;
        logic        vld;
        logic        fl;
        logic        err;
    } exp_t;

    exp_t sb[$];

    fetch_ctrl_if #(.PC_W(16)) im ();

    fetch_ctrl dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .pc_cur_i          (pc_q),
        .load_use_hazard_i (haz),
        .branch_taken_i    (br),
        .branch_target_i   (tgt),
        .trap_req_i        (trap),
        .im                (im),
        .pc_next_o         (nxt),
        .pc_hold_o         (hold),
        .if_valid_o        (vld),
        .if_id_flush_o     (fl_ifid),
        .id_ex_flush_o     (fl_idex),
        .fetch_err_o       (err),
        .state_dbg_o       (st)
    );

    always #5 clk = ~clk;

    // PC register model driven by pc_next/pc_hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= 16'h0000;
        else if (!hold) pc_q <= nxt;
    end

    task automatic cmp(input string tag, input string f,
                       input logic [15:0] obs, input logic [15:0] exv);
        checks++;
        assert (obs === exv) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exv);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] s,
                        input logic rq, input logic [15:0] pc,
                        input logic h, input logic [15:0] n,
                        input logic v, input logic f, input logic e);
        exp_t x;
        x.tag = tag; x.st = s; x.req = rq; x.pc = pc; x.hold = h;
        x.nxt = n; x.vld = v; x.fl = f; x.err = e;
        sb.push_back(x);
    endtask

    task automatic check_pop();
        exp_t x;
        #1;
        x = sb.pop_front();
        cmp(x.tag, "state", {14'd0, st}, {14'd0, x.st});
        cmp(x.tag, "im_req", {15'd0, im.req}, {15'd0, x.req});
        cmp(x.tag, "pc_cur", pc_q, x.pc);
        cmp(x.tag, "im_addr", im.addr, x.pc);
        cmp(x.tag, "pc_hold", {15'd0, hold}, {15'd0, x.hold});
        cmp(x.tag, "pc_next", nxt, x.nxt);
        cmp(x.tag, "if_valid", {15'd0, vld}, {15'd0, x.vld});
        cmp(x.tag, "if_id_flush", {15'd0, fl_ifid}, {15'd0, x.fl});
        cmp(x.tag, "id_ex_flush", {15'd0, fl_idex}, {15'd0, x.fl});
        cmp(x.tag, "fetch_err", {15'd0, err}, {15'd0, x.err});
    endtask

    task automatic drive(input logic a, input logic h, input logic b,
                         input logic [15:0] t, input logic tr);
        @(negedge clk);
        im.ack = a; haz = h; br = b; tgt = t; trap = tr;
    endtask

    initial begin
        im.ack = 1'b0;
        // reset state
        push("reset", 2'd0, 0, 16'h0000, 1, 16'h0000, 0, 0, 0);
        #1;
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        push("boot", 2'd0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        check_pop();

        // 1: back-to-back acks
        drive(1, 0, 0, 0, 0);
        push("seq0", 2'd1, 1, 16'h0000, 0, 16'h0004, 1, 0, 0);
        check_pop();
        drive(1, 0, 0, 0, 0);
        push("seq4", 2'd1, 1, 16'h0004, 0, 16'h0008, 1, 0, 0);
        check_pop();

        // 2: three wait states at pc=8
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0);
            push("wait8", 2'd1, 1, 16'h0008, 1, 16'h0008, 0, 0, 0);
            check_pop();
        end
        drive(1, 0, 0, 0, 0);
        push("ack8", 2'd1, 1, 16'h0008, 0, 16'h000C, 1, 0, 0);
        check_pop();
        drive(1, 0, 0, 0, 0);
        push("seqC", 2'd1, 1, 16'h000C, 0, 16'h0010, 1, 0, 0);
        check_pop();

        // 4: load-use hazard with ack at pc=10
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, 0);
            push("luh10", 2'd1, 1, 16'h0010, 1, 16'h0010, 0, 0, 0);
            check_pop();
        end
        drive(1, 0, 0, 0, 0);
        push("resume10", 2'd1, 1, 16'h0010, 0, 16'h0014, 1, 0, 0);
        check_pop();

        // 3: branch during wait -> DRAIN -> target
        drive(0, 0, 0, 0, 0);
        push("wait14", 2'd1, 1, 16'h0014, 1, 16'h0014, 0, 0, 0);
        check_pop();
        drive(0, 0, 1, 16'h0040, 0);
        push("br_wait", 2'd1, 1, 16'h0014, 1, 16'h0014, 0, 1, 0);
        check_pop();
        drive(0, 0, 0, 0, 0);
        push("drain", 2'd2, 1, 16'h0014, 1, 16'h0014, 0, 0, 0);
        check_pop();
        drive(1, 0, 0, 0, 0);
        push("drain_ack", 2'd2, 1, 16'h0014, 0, 16'h0040, 0, 0, 0);
        check_pop();
        drive(1, 0, 0, 0, 0);
        push("tgt40", 2'd1, 1, 16'h0040, 0, 16'h0044, 1, 0, 0);
        check_pop();

        // 5: no ack -> timeout after 15 waits
        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 0, 0, 0);
            push("to_wait", 2'd1, 1, 16'h0044, 1, 16'h0044, 0, 0, 0);
            check_pop();
        end
        drive(0, 0, 0, 0, 0);
        push("timeout", 2'd1, 0, 16'h0044, 0, 16'h0100, 0, 1, 1);
        check_pop();

        // 6: trap + branch + hazard at FFFC, then wrap
        drive(1, 0, 1, 16'hFFFC, 0);
        push("br_ack", 2'd1, 1, 16'h0100, 0, 16'hFFFC, 0, 1, 0);
        check_pop();
        drive(1, 1, 1, 16'h0200, 1);
        push("trap_all", 2'd1, 1, 16'hFFFC, 0, 16'h0100, 0, 1, 0);
        check_pop();
        drive(1, 0, 1, 16'hFFFC, 0);
        push("br_ack2", 2'd1, 1, 16'h0100, 0, 16'hFFFC, 0, 1, 0);
        check_pop();
        drive(1, 0, 0, 0, 0);
        push("wrap", 2'd1, 1, 16'hFFFC, 0, 16'h0000, 1, 0, 0);
        check_pop();

        // reset mid-handshake drops the request
        drive(0, 0, 0, 0, 0);
        push("pend0", 2'd1, 1, 16'h0000, 1, 16'h0000, 0, 0, 0);
        check_pop();
        @(negedge clk);
        rst_n = 1'b0;
        push("mid_rst", 2'd0, 0, 16'h0000, 1, 16'h0000, 0, 0, 0);
        check_pop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
